// File: rtl/booth_companion_divider.sv
// Sequential signed restoring divider with a Begin/End handshake.
// It produces one quotient bit per clock, then spends one cycle fixing the signs.
module booth_companion_divider #(
    parameter int width = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [width-1:0] Dividend,
    input  logic [width-1:0] Divisor,
    input  logic             Begin,
    output logic [width-1:0] Quotient,
    output logic [width-1:0] Remainder,
    output logic             End,
    output logic             Busy,
    output logic             DivByZero
);

    localparam int               CNT_W     = $clog2(width + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(width - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   quo_q, quo_d;
    logic [width:0]     rem_q, rem_d;
    logic [width-1:0]   dvs_mag_q, dvs_mag_d;
    logic [width-1:0]   dividend_q, dividend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dvd_neg_q, dvd_neg_d;
    logic               dvs_neg_q, dvs_neg_d;
    logic               zero_q, zero_d;
    logic [width-1:0]   quotient_q, quotient_d;
    logic [width-1:0]   remainder_q, remainder_d;
    logic               end_q, end_d;
    logic               dbz_q, dbz_d;

    logic [width+1:0]   shifted;
    logic [width+1:0]   trial;
    logic [width-1:0]   dvd_mag;
    logic [width-1:0]   dvs_mag;

    // Magnitudes are unsigned, so the most-negative input maps cleanly to 2^(width-1).
    assign dvd_mag = Dividend[width-1] ? (~Dividend + width'(1)) : Dividend;
    assign dvs_mag = Divisor[width-1]  ? (~Divisor  + width'(1)) : Divisor;

    assign shifted = {rem_q, quo_q[width-1]};
    assign trial   = shifted - {2'b00, dvs_mag_q};

    // NOTE: every signal gets a default before the case so that no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_mag_d   = dvs_mag_q;
        dividend_d  = dividend_q;
        cnt_d       = cnt_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        end_d       = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (Begin) begin
                    dvd_neg_d  = Dividend[width-1];
                    dvs_neg_d  = Divisor[width-1];
                    quo_d      = dvd_mag;
                    dvs_mag_d  = dvs_mag;
                    dividend_d = Dividend;
                    rem_d      = '0;
                    cnt_d      = '0;
                    zero_d     = (Divisor == '0);
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (!trial[width+1]) begin
                    rem_d = trial[width:0];
                    quo_d = {quo_q[width-2:0], 1'b1};
                end else begin
                    rem_d = shifted[width:0];
                    quo_d = {quo_q[width-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                end else begin
                    quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? (~quo_q + width'(1)) : quo_q;
                    remainder_d = dvd_neg_q ? (~rem_q[width-1:0] + width'(1)) : rem_q[width-1:0];
                end
                end_d   = 1'b1;
                dbz_d   = zero_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_mag_q   <= '0;
            dividend_q  <= '0;
            cnt_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            end_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_mag_q   <= dvs_mag_d;
            dividend_q  <= dividend_d;
            cnt_q       <= cnt_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            end_q       <= end_d;
            dbz_q       <= dbz_d;
        end
    end

    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign End       = end_q;
    assign DivByZero = dbz_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_booth_companion_divider.sv
// Scoreboard bench for booth_companion_divider at width 16.
// The driver queues hand-computed results and a monitor pops them on every End pulse.
module tb_booth_companion_divider;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         CLR;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Begin;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         End;
    logic         Busy;
    logic         DivByZero;

    booth_companion_divider #(.width(W)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Begin     (Begin),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .End       (End),
        .Busy      (Busy),
        .DivByZero (DivByZero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every End pulse must match the oldest outstanding job, 17 edges after its accept edge.
    always @(negedge CLK) begin
        if (End === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_end", 32'(End), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient",   32'(Quotient),  32'(e.q));
                check("remainder",  32'(Remainder), 32'(e.r));
                check("divbyzero",  32'(DivByZero), 32'(e.dbz));
                check("latency",    32'(cyc - e.acc), 32'd17);
                check("busy_at_end", 32'(Busy),     32'd0);
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz, input int acc);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) check({name, "_timeout"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic run_job(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        @(negedge CLK);
        Begin    = 1'b1;
        Dividend = dvd;
        Divisor  = dvs;
        push_exp(q, r, dbz, cyc + 1);
        @(negedge CLK);
        Begin    = 1'b0;
        Dividend = 16'hDEAD;
        Divisor  = 16'h0000;
        check("busy_after_accept", 32'(Busy), 32'd1);
        drain("job");
    endtask

    initial begin
        int acc;
        logic [W-1:0] b2b_dvd [3];
        logic [W-1:0] b2b_dvs [3];
        logic [W-1:0] b2b_q   [3];
        logic [W-1:0] b2b_r   [3];

        CLR = 1'b1; Begin = 1'b0; Dividend = '0; Divisor = '0;
        repeat (3) @(negedge CLK);
        check("rst_quotient",  32'(Quotient),  32'd0);
        check("rst_remainder", 32'(Remainder), 32'd0);
        check("rst_end",       32'(End),       32'd0);
        check("rst_busy",      32'(Busy),      32'd0);
        check("rst_dbz",       32'(DivByZero), 32'd0);
        CLR = 1'b0;

        run_job(16'd100,  16'd7,      16'h000E, 16'h0002, 1'b0);
        run_job(-16'sd100, 16'd7,     16'hFFF2, 16'hFFFE, 1'b0);
        run_job(16'd100,  -16'sd7,    16'hFFF2, 16'h0002, 1'b0);
        run_job(-16'sd100, -16'sd7,   16'h000E, 16'hFFFE, 1'b0);
        run_job(16'h8000, 16'hFFFF,   16'h8000, 16'h0000, 1'b0);
        run_job(16'h8000, 16'h0001,   16'h8000, 16'h0000, 1'b0);
        run_job(16'h8000, 16'h8000,   16'h0001, 16'h0000, 1'b0);
        run_job(16'h7FFF, 16'h8000,   16'h0000, 16'h7FFF, 1'b0);
        run_job(16'd5,    16'd0,      16'hFFFF, 16'h0005, 1'b1);
        check("dbz_holds", 32'(DivByZero), 32'd1);
        run_job(16'd9,    16'd3,      16'h0003, 16'h0000, 1'b0);
        run_job(-16'sd5,  16'd0,      16'hFFFF, 16'hFFFB, 1'b1);

        // Back-to-back with Begin held high; operands scrambled between accept edges.
        b2b_dvd[0] = 16'd1000;   b2b_dvs[0] = 16'd10;    b2b_q[0] = 16'h0064; b2b_r[0] = 16'h0000;
        b2b_dvd[1] = -16'sd1000; b2b_dvs[1] = 16'd33;    b2b_q[1] = 16'hFFE2; b2b_r[1] = 16'hFFF6;
        b2b_dvd[2] = 16'd12345;  b2b_dvs[2] = -16'sd128; b2b_q[2] = 16'hFFA0; b2b_r[2] = 16'h0039;
        @(negedge CLK);
        Begin    = 1'b1;
        Dividend = b2b_dvd[0];
        Divisor  = b2b_dvs[0];
        acc      = cyc + 1;
        push_exp(b2b_q[0], b2b_r[0], 1'b0, acc);
        for (int n = 1; n < 3; n++) begin
            do begin
                @(negedge CLK);
                Dividend = 16'h5A5A ^ 16'(cyc);
                Divisor  = 16'(cyc) | 16'h0001;
            end while (cyc != acc + 17);
            Dividend = b2b_dvd[n];
            Divisor  = b2b_dvs[n];
            acc      = cyc + 1;
            push_exp(b2b_q[n], b2b_r[n], 1'b0, acc);
        end
        @(negedge CLK);
        Begin    = 1'b0;
        Dividend = 16'h1111;
        Divisor  = 16'h0002;
        drain("b2b");

        // Mid-job CLR at E8: abandoned job produces no End.
        @(negedge CLK);
        Begin    = 1'b1;
        Dividend = 16'd30000;
        Divisor  = 16'd7;
        acc      = cyc + 1;
        @(negedge CLK);
        Begin = 1'b0;
        while (cyc != acc + 7) @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("clr_quotient",  32'(Quotient),  32'd0);
        check("clr_remainder", 32'(Remainder), 32'd0);
        check("clr_end",       32'(End),       32'd0);
        check("clr_busy",      32'(Busy),      32'd0);
        check("clr_dbz",       32'(DivByZero), 32'd0);
        repeat (25) @(negedge CLK);
        run_job(16'd30000, 16'd7, 16'h10BD, 16'h0005, 1'b0);

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
